// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and data-memory req/ack access controller.
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned lw/sw with bus_err.
module mem_access_stage #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_aluout,
   input  logic [31:0] ex_busB,
   input  logic [29:0] ex_btarg,
   input  logic        ex_zero,
   input  logic        ex_overflow,
   input  logic [4:0]  ex_rw,
   input  logic        ex_regwr,
   input  logic        ex_memwr,
   input  logic        ex_memtoreg,
   input  logic        ex_branch,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_regwr,
   output logic [4:0]  wb_rw,
   output logic [31:0] wb_data,
   output logic        br_taken,
   output logic [29:0] br_target,
   output logic        exc_ovf,
   output logic        bus_err
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  pend_rw_q, pend_rw_d;
   logic        pend_regwr_q, pend_regwr_d;
   logic        pend_exc_q, pend_exc_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_regwr_q, wb_regwr_d;
   logic [4:0]  wb_rw_q, wb_rw_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        br_taken_q, br_taken_d;
   logic [29:0] br_target_q, br_target_d;
   logic        exc_ovf_q, exc_ovf_d;
   logic        bus_err_q, bus_err_d;

   logic accept;
   logic is_mem;
   logic regwr_ok;
   logic misalign;

   assign ex_ready = (state_q == IDLE);
   assign accept   = ex_valid & ex_ready;
   assign is_mem   = ex_memwr | ex_memtoreg;
   assign regwr_ok = ex_regwr & ~ex_overflow & (ex_rw != 5'd0);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = is_mem & (ex_aluout[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      pend_rw_d    = pend_rw_q;
      pend_regwr_d = pend_regwr_q;
      pend_exc_d   = pend_exc_q;
      wb_valid_d   = 1'b0;
      wb_regwr_d   = 1'b0;
      wb_rw_d      = wb_rw_q;
      wb_data_d    = wb_data_q;
      br_taken_d   = 1'b0;
      br_target_d  = br_target_q;
      exc_ovf_d    = 1'b0;
      bus_err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               br_taken_d  = ex_branch & ex_zero;
               br_target_d = ex_btarg;
               if (is_mem && !misalign) begin
                  state_d      = ACCESS;
                  wcnt_d       = 8'd0;
                  req_d        = 1'b1;
                  we_d         = ex_memwr;
                  addr_d       = ex_aluout;
                  wdata_d      = ex_busB;
                  pend_rw_d    = ex_rw;
                  // memwr wins when both memory controls are set
                  pend_regwr_d = regwr_ok & ~ex_memwr;
                  pend_exc_d   = ex_overflow & ex_regwr;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_rw_d    = ex_rw;
                  exc_ovf_d  = ex_overflow & ex_regwr;
                  if (misalign) begin
                     bus_err_d = 1'b1;
                  end else begin
                     wb_data_d  = ex_aluout;
                     wb_regwr_d = regwr_ok;
                  end
               end
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_rw_d    = pend_rw_q;
               wb_regwr_d = pend_regwr_q;
               exc_ovf_d  = pend_exc_q;
               if (!we_q) begin
                  wb_data_d = dmem_rdata;
               end
            end else if (wcnt_q == LIMIT_M1) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               wcnt_d     = wcnt_q + 8'd1;
               wb_valid_d = 1'b1;
               wb_rw_d    = pend_rw_q;
               exc_ovf_d  = pend_exc_q;
               bus_err_d  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wcnt_q       <= 8'd0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         pend_rw_q    <= 5'd0;
         pend_regwr_q <= 1'b0;
         pend_exc_q   <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_regwr_q   <= 1'b0;
         wb_rw_q      <= 5'd0;
         wb_data_q    <= 32'd0;
         br_taken_q   <= 1'b0;
         br_target_q  <= 30'd0;
         exc_ovf_q    <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pend_rw_q    <= pend_rw_d;
         pend_regwr_q <= pend_regwr_d;
         pend_exc_q   <= pend_exc_d;
         wb_valid_q   <= wb_valid_d;
         wb_regwr_q   <= wb_regwr_d;
         wb_rw_q      <= wb_rw_d;
         wb_data_q    <= wb_data_d;
         br_taken_q   <= br_taken_d;
         br_target_q  <= br_target_d;
         exc_ovf_q    <= exc_ovf_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_regwr   = wb_regwr_q;
   assign wb_rw      = wb_rw_q;
   assign wb_data    = wb_data_q;
   assign br_taken   = br_taken_q;
   assign br_target  = br_target_q;
   assign exc_ovf    = exc_ovf_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU-op vector table plus
// hand-written lw/sw/timeout/reset sequences.
module tb_mem_access_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_aluout;
   logic [31:0] ex_busB;
   logic [29:0] ex_btarg;
   logic        ex_zero;
   logic        ex_overflow;
   logic [4:0]  ex_rw;
   logic        ex_regwr;
   logic        ex_memwr;
   logic        ex_memtoreg;
   logic        ex_branch;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic        wb_regwr;
   logic [4:0]  wb_rw;
   logic [31:0] wb_data;
   logic        br_taken;
   logic [29:0] br_target;
   logic        exc_ovf;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   mem_access_stage #(.WAIT_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluout(ex_aluout), .ex_busB(ex_busB), .ex_btarg(ex_btarg),
      .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_rw(ex_rw),
      .ex_regwr(ex_regwr), .ex_memwr(ex_memwr),
      .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_rw(wb_rw),
      .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target),
      .exc_ovf(exc_ovf), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [4:0]  rw;
      logic        regwr;
      logic        ovf;
      logic        br;
      logic        zero;
      logic [29:0] btarg;
      logic        e_regwr;
      logic        e_exc;
      logic        e_br;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      ex_valid    = 1'b0;
      ex_aluout   = 32'd0;
      ex_busB     = 32'd0;
      ex_btarg    = 30'd0;
      ex_zero     = 1'b0;
      ex_overflow = 1'b0;
      ex_rw       = 5'd0;
      ex_regwr    = 1'b0;
      ex_memwr    = 1'b0;
      ex_memtoreg = 1'b0;
      ex_branch   = 1'b0;
   endtask

   task automatic drive_mem(input logic [31:0] a, input logic [31:0] d,
                            input logic [4:0] rw, input logic rg,
                            input logic mw, input logic mr);
      idle_in();
      ex_valid    = 1'b1;
      ex_aluout   = a;
      ex_busB     = d;
      ex_rw       = rw;
      ex_regwr    = rg;
      ex_memwr    = mw;
      ex_memtoreg = mr;
   endtask

   // counts dmem_req-high cycles, raising ack in request cycle ack_at
   task automatic mem_run(input int ack_at, input logic [31:0] rd,
                          output int n);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (!dmem_req) break;
         n++;
         chk("ex_ready_busy", ex_ready, 0);
         chk("wb_valid_busy", wb_valid, 0);
         if (n == ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rd;
         end
         tick();
         dmem_ack = 1'b0;
      end
   endtask

   initial begin
      int n;
      vecs[0] = '{32'h5, 5'd8, 1, 0, 0, 0, 30'h0, 1, 0, 0};
      vecs[1] = '{32'h7, 5'd9, 1, 0, 0, 0, 30'h0, 1, 0, 0};
      vecs[2] = '{32'h8000_0000, 5'd5, 1, 1, 0, 0, 30'h0, 0, 1, 0};
      vecs[3] = '{32'h0, 5'd0, 0, 0, 1, 1, 30'h100, 0, 0, 1};
      vecs[4] = '{32'h4, 5'd0, 0, 0, 1, 0, 30'h200, 0, 0, 0};
      vecs[5] = '{32'h33, 5'd0, 1, 0, 0, 0, 30'h0, 0, 0, 0};
      vecs[6] = '{32'h7FFF_0000, 5'd3, 0, 1, 0, 0, 30'h3, 0, 0, 0};

      idle_in();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      rst_n      = 1'b0;
      #12;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_br_target", br_target, 0);
      chk("rst_bus_err", bus_err, 0);
      rst_n = 1'b1;
      chk("rst_ex_ready", ex_ready, 1);

      for (int i = 0; i < 7; i++) begin
         idle_in();
         ex_valid    = 1'b1;
         ex_aluout   = vecs[i].alu;
         ex_rw       = vecs[i].rw;
         ex_regwr    = vecs[i].regwr;
         ex_overflow = vecs[i].ovf;
         ex_branch   = vecs[i].br;
         ex_zero     = vecs[i].zero;
         ex_btarg    = vecs[i].btarg;
         tick();
         chk($sformatf("v%0d_ex_ready", i), ex_ready, 1);
         chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
         chk($sformatf("v%0d_wb_regwr", i), wb_regwr, vecs[i].e_regwr);
         chk($sformatf("v%0d_wb_rw", i), wb_rw, vecs[i].rw);
         chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].alu);
         chk($sformatf("v%0d_exc_ovf", i), exc_ovf, vecs[i].e_exc);
         chk($sformatf("v%0d_br_taken", i), br_taken, vecs[i].e_br);
         chk($sformatf("v%0d_br_target", i), br_target, vecs[i].btarg);
         chk($sformatf("v%0d_dmem_req", i), dmem_req, 0);
      end

      idle_in();
      tick();
      chk("idle_wb_valid", wb_valid, 0);
      chk("idle_wb_regwr", wb_regwr, 0);
      chk("idle_exc_ovf", exc_ovf, 0);
      chk("idle_wb_rw_hold", wb_rw, 5'd3);
      chk("idle_wb_data_hold", wb_data, 32'h7FFF_0000);
      chk("idle_br_target_hold", br_target, 30'h3);

      // lw 0x40, ack in third request cycle
      drive_mem(32'h40, 32'h0, 5'd4, 1, 0, 1);
      tick();
      idle_in();
      chk("lw_addr", dmem_addr, 32'h40);
      chk("lw_we", dmem_we, 0);
      mem_run(3, 32'hDEAD_BEEF, n);
      chk("lw_req_cycles", n, 3);
      chk("lw_wb_valid", wb_valid, 1);
      chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("lw_wb_rw", wb_rw, 5'd4);
      chk("lw_wb_regwr", wb_regwr, 1);
      chk("lw_ex_ready", ex_ready, 1);

      // sw 0x80, immediate ack
      drive_mem(32'h80, 32'h1234_5678, 5'd7, 1, 1, 0);
      tick();
      idle_in();
      chk("sw_we", dmem_we, 1);
      chk("sw_wdata", dmem_wdata, 32'h1234_5678);
      chk("sw_addr", dmem_addr, 32'h80);
      mem_run(1, 32'hFFFF_FFFF, n);
      chk("sw_req_cycles", n, 1);
      chk("sw_wb_valid", wb_valid, 1);
      chk("sw_wb_regwr", wb_regwr, 0);
      chk("sw_wb_data_hold", wb_data, 32'hDEAD_BEEF);

      // both memory controls set: treated as a store
      drive_mem(32'h84, 32'hA5A5_0001, 5'd2, 1, 1, 1);
      tick();
      idle_in();
      chk("both_we", dmem_we, 1);
      mem_run(1, 32'h0, n);
      chk("both_wb_regwr", wb_regwr, 0);

      // timeout
      drive_mem(32'h100, 32'h0, 5'd6, 1, 0, 1);
      tick();
      idle_in();
      mem_run(0, 32'h0, n);
      chk("to_req_cycles", n, 15);
      chk("to_bus_err", bus_err, 1);
      chk("to_wb_valid", wb_valid, 1);
      chk("to_wb_regwr", wb_regwr, 0);
      chk("to_ex_ready", ex_ready, 1);
      tick();
      chk("to_bus_err_pulse", bus_err, 0);
      chk("to_wb_valid_pulse", wb_valid, 0);

      // ack on the limit cycle wins
      drive_mem(32'h104, 32'h0, 5'd2, 1, 0, 1);
      tick();
      idle_in();
      mem_run(15, 32'hCAFE_F00D, n);
      chk("lim_req_cycles", n, 15);
      chk("lim_bus_err", bus_err, 0);
      chk("lim_wb_regwr", wb_regwr, 1);
      chk("lim_wb_data", wb_data, 32'hCAFE_F00D);

      // misaligned lw
      drive_mem(32'h41, 32'h0, 5'd1, 1, 0, 1);
      tick();
      idle_in();
`ifdef MEM_ALIGN_CHECK_EN
      chk("mis_req", dmem_req, 0);
      chk("mis_bus_err", bus_err, 1);
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_wb_regwr", wb_regwr, 0);
`else
      chk("mis_addr", dmem_addr, 32'h41);
      mem_run(1, 32'h0000_0077, n);
      chk("mis_req_cycles", n, 1);
      chk("mis_wb_data", wb_data, 32'h77);
`endif

      // reset mid-access
      drive_mem(32'h100, 32'h0, 5'd4, 1, 0, 1);
      tick();
      idle_in();
      tick();
      chk("rm_req_before", dmem_req, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rm_req_async", dmem_req, 0);
      chk("rm_wb_valid", wb_valid, 0);
      chk("rm_dmem_addr", dmem_addr, 0);
      chk("rm_wb_data", wb_data, 0);
      chk("rm_wb_rw", wb_rw, 0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("rm_ex_ready", ex_ready, 1);
      chk("rm_req_after", dmem_req, 0);
      chk("rm_wb_valid_after", wb_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller, directly downstream of the execute unit.
- Latches the ALU result, store data, branch target and control bits for each instruction leaving EX.
- Performs lw/sw through a req/ack data-memory port; emits writeback data/controls and the branch redirect.
- Stalls EX via ex_ready while a memory access is outstanding.

Parameters:
- WAIT_LIMIT, 15: max cycles dmem_req may stay high without dmem_ack before the access is aborted (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  stage can accept; accept = ex_valid & ex_ready at rising edge
- ex_aluout  in  32  ALU result / memory address
- ex_busB  in  32  store data
- ex_btarg  in  30  branch target word address
- ex_zero  in  1  ALU zero flag
- ex_overflow  in  1  ALU overflow flag
- ex_rw  in  5  destination register
- ex_regwr, ex_memwr, ex_memtoreg, ex_branch  in  1 each  control bits (memtoreg = lw, memwr = sw)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  request complete; dmem_rdata valid in same cycle
- dmem_rdata  in  32  load data
- wb_valid  out  1  one-cycle pulse: writeback fields valid
- wb_regwr  out  1  register write enable
- wb_rw  out  5  destination register
- wb_data  out  32  ALU result or load data
- br_taken  out  1  one-cycle pulse: redirect PC
- br_target  out  30  redirect target
- exc_ovf  out  1  one-cycle pulse: arithmetic overflow
- bus_err  out  1  one-cycle pulse: access aborted (timeout)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, wait counter 0. Asynchronous: dmem_req falls immediately, even mid-access; the in-flight instruction is discarded.
- FSM states IDLE, ACCESS.
- ex_ready = (state == IDLE).
- IDLE, accept, non-memory op (memwr = memtoreg = 0): stays in IDLE. Next cycle: wb_valid = 1, wb_data = ex_aluout, wb_rw = ex_rw.
  - Throughput 1 instr/cycle; latency 1.
- IDLE, accept, memory op: goes to ACCESS. Registers dmem_addr = ex_aluout, dmem_wdata = ex_busB, dmem_we = ex_memwr. dmem_req = 1 from the next cycle; address/data/we held stable until ack.
  - If both memwr and memtoreg are set, the op is treated as a store.
- ACCESS, dmem_ack sampled at an edge:
  - dmem_req drops; return to IDLE.
  - Next cycle: wb_valid = 1, wb_data = dmem_rdata for a load. For a store: wb_valid = 1 and wb_regwr = 0.
  - Minimum memory latency: 2 cycles accept-to-wb_valid.
- Wait counter: cleared on entry to ACCESS, increments each ACCESS cycle without ack. When it reaches WAIT_LIMIT without ack: drop dmem_req, pulse bus_err, wb_valid = 1 with wb_regwr = 0, return to IDLE. An ack on the limit cycle wins over timeout.
- wb_regwr = ex_regwr & ~ex_overflow & (ex_rw != 0). exc_ovf pulses with wb_valid when ex_overflow & ex_regwr.
- br_taken = ex_branch & ex_zero, registered one cycle after accept regardless of op type. br_target = ex_btarg latched at accept, held until the next accept.
- wb_rw, wb_data hold their last value when wb_valid = 0.
- ex_valid while ex_ready = 0: ignored; EX must hold its inputs.
- No accept in a cycle: all pulse outputs 0 next cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a memory op with ex_aluout[1:0] != 0 never enters ACCESS and never asserts dmem_req. Next cycle it pulses bus_err with wb_valid = 1, wb_regwr = 0.
- Undefined: the address is passed unchanged; memory ignores the low bits.

Test Plan:
- Reset mid-access: accept lw 0x100, hold dmem_ack = 0, pull rst_n low mid-cycle -> dmem_req = 0 immediately; all outputs 0; after release ex_ready = 1.
- Back-to-back ALU ops: add rw = 8 result 0x5, then rw = 9 result 0x7 on consecutive cycles -> wb_valid on 2 consecutive cycles with (8, 0x5), (9, 0x7); ex_ready stays 1.
- lw 0x00000040 with ack 3 cycles after req, rdata 0xDEADBEEF, rw = 4:
  - dmem_req high exactly 3 cycles, ex_ready low throughout.
  - wb_data = 0xDEADBEEF, wb_rw = 4, wb_regwr = 1.
- sw addr 0x80, busB 0x12345678, immediate ack -> dmem_we = 1, dmem_wdata = 0x12345678; wb_valid = 1 with wb_regwr = 0; total 2 cycles.
- beq with zero = 1, btarg = 0x0000100 -> br_taken pulse 1 cycle, br_target = 0x0000100. Same with zero = 0 -> br_taken = 0.
- Overflow: regwr = 1, overflow = 1, rw = 5 -> exc_ovf = 1, wb_regwr = 0. Timeout: lw, no ack for WAIT_LIMIT = 15 cycles -> bus_err pulse, wb_regwr = 0, ex_ready returns to 1.
